// File: rtl/mux_onehot_reg.sv
// N-way one-hot data selector with a registered output stage, valid/ready
// handshake and a sticky, saturating counter of illegal selects.
module mux_onehot_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = $clog2(NUM_INPUTS),
  parameter int ERR_CNT_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] iData,
  input  logic [NUM_INPUTS-1:0]            select,
  input  logic                             iValid,
  output logic                             iReady,
  output logic                             oValid,
  input  logic                             oReady,
  output logic [DATA_WIDTH-1:0]            oData,
  output logic [SEL_W-1:0]                 oSel,
  output logic                             errFlag,
  output logic [ERR_CNT_W-1:0]             errCount,
  input  logic                             errClear
);

  logic                  valid_q,  valid_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic [SEL_W-1:0]      sel_q,    sel_d;
  logic                  flag_q,   flag_d;
  logic [ERR_CNT_W-1:0]  cnt_q,    cnt_d;

  logic                  accept;
  logic                  legal;
  logic                  illegal_acc;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [SEL_W-1:0]      sel_idx;

  // Output register is free when empty or being drained this cycle.
  assign iReady = !valid_q || oReady;
  assign accept = iValid && iReady;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign legal       = (select != '0) && ((select & (select - NUM_INPUTS'(1))) == '0);
  assign illegal_acc = accept && !legal;

  // AND-OR select tree plus binary encoding; only meaningful when legal.
  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (select[k]) begin
        sel_data = sel_data | iData[k*DATA_WIDTH +: DATA_WIDTH];
        sel_idx  = sel_idx  | SEL_W'(k);
      end
    end
  end

  // Next state of the output stage: load on legal accept, drain on oReady.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (accept && legal) begin
      valid_d = 1'b1;
      data_d  = sel_data;
      sel_d   = sel_idx;
    end else if (oReady) begin
      valid_d = 1'b0;
    end
  end

  // Next state of error tracking; an illegal accept outranks a clear.
  always_comb begin
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (illegal_acc) begin
      flag_d = 1'b1;
      if (errClear) begin
        cnt_d = ERR_CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + ERR_CNT_W'(1);
      end
    end else if (errClear) begin
      flag_d = 1'b0;
      cnt_d  = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oValid   = valid_q;
  assign oData    = data_q;
  assign oSel     = sel_q;
  assign errFlag  = flag_q;
  assign errCount = cnt_q;

endmodule

// File: tb/tb_mux_onehot_reg.sv
// Directed, table-driven bench for mux_onehot_reg (4 x 32-bit channels).
module tb_mux_onehot_reg;

  localparam int DW = 32;
  localparam int NI = 4;
  localparam int SW = 2;
  localparam int CW = 8;

  logic             clk;
  logic             rst;
  logic [NI*DW-1:0] iData;
  logic [NI-1:0]    select;
  logic             iValid;
  logic             iReady;
  logic             oValid;
  logic             oReady;
  logic [DW-1:0]    oData;
  logic [SW-1:0]    oSel;
  logic             errFlag;
  logic [CW-1:0]    errCount;
  logic             errClear;

  int checks = 0;
  int errors = 0;

  mux_onehot_reg #(
    .DATA_WIDTH(DW),
    .NUM_INPUTS(NI),
    .SEL_W     (SW),
    .ERR_CNT_W (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .iData   (iData),
    .select  (select),
    .iValid  (iValid),
    .iReady  (iReady),
    .oValid  (oValid),
    .oReady  (oReady),
    .oData   (oData),
    .oSel    (oSel),
    .errFlag (errFlag),
    .errCount(errCount),
    .errClear(errClear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic        vld;
    logic        ordy;
    logic        clr;
    logic        scramble;
    logic        e_irdy;
    logic        e_oval;
    logic [31:0] e_data;
    logic [1:0]  e_sel;
    logic        e_flag;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data(input logic scramble);
    logic [127:0] base;
    base = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    iData = scramble ? ~base : base;
  endtask

  function automatic vec_t mk(input logic [3:0] sel, input logic vld, input logic ordy,
                              input logic clr, input logic scr, input logic irdy,
                              input logic oval, input logic [31:0] d, input logic [1:0] s,
                              input logic f, input logic [7:0] c);
    vec_t v;
    v.sel = sel; v.vld = vld; v.ordy = ordy; v.clr = clr; v.scramble = scr;
    v.e_irdy = irdy; v.e_oval = oval; v.e_data = d; v.e_sel = s;
    v.e_flag = f; v.e_cnt = c;
    return v;
  endfunction

  initial begin
    //           sel     v  rdy clr scr irdy oval data          sel  f  cnt
    vecs[0]  = mk(4'b0100, 1, 1, 0, 0, 1, 1, 32'h33333333, 2'd2, 0, 8'd0);
    vecs[1]  = mk(4'b0001, 1, 1, 0, 0, 1, 1, 32'h11111111, 2'd0, 0, 8'd0);
    vecs[2]  = mk(4'b0010, 1, 1, 0, 0, 1, 1, 32'h22222222, 2'd1, 0, 8'd0);
    vecs[3]  = mk(4'b1000, 1, 1, 0, 0, 1, 1, 32'h44444444, 2'd3, 0, 8'd0);
    vecs[4]  = mk(4'b0010, 1, 1, 0, 0, 1, 1, 32'h22222222, 2'd1, 0, 8'd0);
    vecs[5]  = mk(4'b0001, 1, 0, 0, 1, 0, 1, 32'h22222222, 2'd1, 0, 8'd0);
    vecs[6]  = mk(4'b1000, 1, 0, 0, 1, 0, 1, 32'h22222222, 2'd1, 0, 8'd0);
    vecs[7]  = mk(4'b0100, 1, 0, 0, 0, 0, 1, 32'h22222222, 2'd1, 0, 8'd0);
    vecs[8]  = mk(4'b0001, 0, 1, 0, 0, 1, 0, 32'h22222222, 2'd1, 0, 8'd0);
    vecs[9]  = mk(4'b0000, 1, 1, 0, 0, 1, 0, 32'h22222222, 2'd1, 1, 8'd1);
    vecs[10] = mk(4'b0110, 1, 1, 0, 0, 1, 0, 32'h22222222, 2'd1, 1, 8'd2);
    vecs[11] = mk(4'b1100, 1, 1, 1, 0, 1, 0, 32'h22222222, 2'd1, 1, 8'd1);
    vecs[12] = mk(4'b1000, 1, 1, 0, 0, 1, 1, 32'h44444444, 2'd3, 1, 8'd1);
    vecs[13] = mk(4'b0000, 1, 0, 0, 0, 0, 1, 32'h44444444, 2'd3, 1, 8'd1);
    vecs[14] = mk(4'b0011, 1, 1, 0, 0, 1, 0, 32'h44444444, 2'd3, 1, 8'd2);
    vecs[15] = mk(4'b0000, 0, 1, 1, 0, 1, 0, 32'h44444444, 2'd3, 0, 8'd0);

    rst = 1'b1; iValid = 1'b0; oReady = 1'b0; errClear = 1'b0; select = '0;
    set_data(1'b0);
    #12;
    chk("reset_oValid",   32'(oValid),   32'd0);
    chk("reset_oData",    oData,         32'd0);
    chk("reset_oSel",     32'(oSel),     32'd0);
    chk("reset_errFlag",  32'(errFlag),  32'd0);
    chk("reset_errCount", 32'(errCount), 32'd0);
    chk("reset_iReady",   32'(iReady),   32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      select = vecs[i].sel; iValid = vecs[i].vld; oReady = vecs[i].ordy;
      errClear = vecs[i].clr; set_data(vecs[i].scramble);
      #1;
      chk($sformatf("v%0d_iReady", i), 32'(iReady), 32'(vecs[i].e_irdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_oValid", i),   32'(oValid),   32'(vecs[i].e_oval));
      chk($sformatf("v%0d_oData", i),    oData,         vecs[i].e_data);
      chk($sformatf("v%0d_oSel", i),     32'(oSel),     32'(vecs[i].e_sel));
      chk($sformatf("v%0d_errFlag", i),  32'(errFlag),  32'(vecs[i].e_flag));
      chk($sformatf("v%0d_errCount", i), 32'(errCount), 32'(vecs[i].e_cnt));
    end

    // Saturation: 300 back-to-back illegal accepts.
    select = 4'b0000; iValid = 1'b1; oReady = 1'b1; errClear = 1'b0; set_data(1'b0);
    repeat (300) @(posedge clk);
    #1;
    iValid = 1'b0;
    chk("sat_errCount", 32'(errCount), 32'hFF);
    chk("sat_errFlag",  32'(errFlag),  32'd1);
    chk("sat_oValid",   32'(oValid),   32'd0);
    errClear = 1'b1;
    @(posedge clk); #1;
    errClear = 1'b0;
    chk("clr_errCount", 32'(errCount), 32'd0);
    chk("clr_errFlag",  32'(errFlag),  32'd0);

    // Async reset during a stall with a pending result and a nonzero count.
    select = 4'b0000; iValid = 1'b1; oReady = 1'b1;
    @(posedge clk); #1;
    select = 4'b0001;
    @(posedge clk); #1;
    oReady = 1'b0; iValid = 1'b1; select = 4'b0010;
    chk("pre_rst_oValid",   32'(oValid),   32'd1);
    chk("pre_rst_oData",    oData,         32'h11111111);
    chk("pre_rst_errCount", 32'(errCount), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_oValid",   32'(oValid),   32'd0);
    chk("async_rst_oData",    oData,         32'd0);
    chk("async_rst_errCount", 32'(errCount), 32'd0);
    chk("async_rst_errFlag",  32'(errFlag),  32'd0);
    chk("async_rst_iReady",   32'(iReady),   32'd1);
    #4;
    rst = 1'b0;
    select = 4'b0100; iValid = 1'b1; oReady = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
    chk("post_rst_oValid", 32'(oValid), 32'd1);
    chk("post_rst_oData",  oData,       32'h33333333);
    chk("post_rst_oSel",   32'(oSel),   32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
